tstate_sequencer: RTL
=====================

# tstate_sequencer

Parametrised T-state generator for the SAP control unit. It is the successor to the fixed six-state ring counter. It produces a one-hot timing vector and an encoded state index, and terminates each instruction early according to a per-instruction length supplied by the decoder. It also supports run/hold, single-step and halt, and counts completed instructions. It sits between the clock/reset network and the control-word decoder.

## Interface
- N_STATES, 6, total T-states per instruction (≥2)
- FETCH_STATES, 3, fetch T-states common to every instruction (1..N_STATES)
- CNT_W, 16, width of instruction counter
- Derived: IDX_W = clog2(N_STATES); LEN_W = clog2(N_STATES+1)

Ports:
- clk  in  1  system clock, all state on rising edge
- res  in  1  reset, asynchronous, active-high
- en  in  1  run enable; 0 = hold current state
- mode_step  in  1  1 = single-step mode
- step  in  1  step request; rising edge (registered detect) permits one advance
- len  in  LEN_W  instruction length in T-states, from decoder
- hlt  in  1  halt request
- t  out  N_STATES  one-hot T-state, bit i = T(i+1)
- idx  out  IDX_W  encoded current state, 0-based
- fetch  out  1  idx < FETCH_STATES
- last  out  1  current state is final state of the current instruction
- halted  out  1  halt latch
- instr_cnt  out  CNT_W  completed instructions, wraps

## Operation
- step_rise = step & ~step_q; step_q is a register.
- adv = ~halted & ~hlt & en & (~mode_step | step_rise).
- clen = clamp(len): 0 or >N_STATES → N_STATES; <FETCH_STATES → FETCH_STATES; else len.
- len_reg (LEN_W, internal) loads clen on an adv edge when idx == FETCH_STATES-1.
- Limit lim:
  - idx < FETCH_STATES-1 → N_STATES
  - idx == FETCH_STATES-1 → clen (live input)
  - idx ≥ FETCH_STATES → len_reg
- last = (idx == lim-1). It is combinational from idx, len and len_reg.
- On an adv edge:
  - last → idx = 0 and instr_cnt = instr_cnt + 1 (mod 2^CNT_W)
  - otherwise idx = idx + 1
- No adv → all state held.
- Halt: hlt = 1 on any clock edge sets halted, regardless of en, mode_step or step. That edge does not advance. halted clears only via res.
- t = one-hot of idx, registered alongside idx; never all-zero, never multi-hot.
- fetch is derived from registered idx.
- Unreachable idx ≥ N_STATES is recovered to 0 on the next adv edge.

## Timing
- Reset (async, immediate): idx = 0, t = 1 (T1), fetch = 1, halted = 0, instr_cnt = 0, len_reg = N_STATES, step_q = 0.
- While res is high, every output holds its reset value.
- Release of res takes effect at the next clk edge without a glitch.
- Latency: one clk edge from adv to the new t/idx.
- halted asserts one edge after hlt is sampled.
- step_rise → advance on the same edge the rise is sampled.
- A step held high advances exactly once. A new advance requires step low for ≥1 edge.
- Priority: res > hlt > en/step.
- res mid-instruction aborts the instruction; instr_cnt is not incremented.
- len is sampled only at the idx == FETCH_STATES-1 adv edge. Changes at any other time are ignored for the current instruction.
- FETCH_STATES == N_STATES: every instruction has length N_STATES; len is effectively ignored.

## Test plan
Defaults used: N_STATES = 6, FETCH_STATES = 3.
- Full-length run: res pulse 10 ns, then en = 1, len = 6.
  - t cycles 000001 → 000010 → 000100 → 001000 → 010000 → 100000 → 000001.
  - last is high only at 100000.
  - instr_cnt increments once per 6 edges.
- Early termination: len = 4 at idx 2.
  - t: 000001 → 000010 → 000100 → 001000 → 000001; last high at idx 3.
  - Changing len to 6 during idx 3 has no effect.
- Fetch-only and clamping:
  - len = 3 → t: 1 → 2 → 4 → 1.
  - len = 2 → behaves as 3.
  - len = 0 or 7 → behaves as 6.
- Single-step: mode_step = 1, step held high 5 cycles → exactly one advance. Then step toggled 0/1 three times → three advances. en = 0 blocks steps.
- Halt and reset:
  - hlt pulsed at idx 4 → t holds 010000, halted = 1; en/step activity has no effect.
  - Async res asserted between clk edges → t = 000001, halted = 0, instr_cnt = 0 immediately.
- Counter wrap: CNT_W = 4, len = 3, run 16 instructions → instr_cnt reaches 15, then 0 on the 16th completion.

Source files
------------

// File: rtl/tstate_sequencer_if.sv
// Control-unit timing bus between the T-state sequencer and its surroundings.
// The master side drives run control and instruction length; the slave is the sequencer.
interface tstate_sequencer_if #(
    parameter int N_STATES = 6,
    parameter int CNT_W    = 16
);
    localparam int IDX_W = $clog2(N_STATES);
    localparam int LEN_W = $clog2(N_STATES + 1);

    logic                en;
    logic                mode_step;
    logic                step;
    logic [LEN_W-1:0]    len;
    logic                hlt;
    logic [N_STATES-1:0] t;
    logic [IDX_W-1:0]    idx;
    logic                fetch;
    logic                last;
    logic                halted;
    logic [CNT_W-1:0]    instr_cnt;

    modport master (
        output en, mode_step, step, len, hlt,
        input  t, idx, fetch, last, halted, instr_cnt
    );

    modport slave (
        input  en, mode_step, step, len, hlt,
        output t, idx, fetch, last, halted, instr_cnt
    );
endinterface

// File: rtl/tstate_sequencer.sv
// Parametrised T-state generator: one-hot timing vector, per-instruction early
// termination, run/hold, single-step, halt latch and completed-instruction counter.
module tstate_sequencer #(
    parameter int N_STATES     = 6,
    parameter int FETCH_STATES = 3,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              res,
    tstate_sequencer_if.slave bus
);
    localparam int IDX_W = $clog2(N_STATES);
    localparam int LEN_W = $clog2(N_STATES + 1);
    localparam logic [LEN_W-1:0] N_L    = LEN_W'(N_STATES);
    localparam logic [LEN_W-1:0] F_L    = LEN_W'(FETCH_STATES);
    localparam logic [LEN_W-1:0] F_LAST = LEN_W'(FETCH_STATES - 1);
    localparam logic [LEN_W-1:0] ONE_L  = LEN_W'(1);

    typedef enum logic {RUNNING, HALTED} run_state_t;

    run_state_t          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [N_STATES-1:0] t_q;
    logic [LEN_W-1:0]    len_reg_q, len_reg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                step_q;
    logic                step_rise;
    logic                adv;
    logic                last;
    logic [LEN_W-1:0]    idx_ext;
    logic [LEN_W-1:0]    clen;
    logic [LEN_W-1:0]    lim;

    // Length of the current instruction: fetch states always run, the decoder's
    // length is taken live at the last fetch state and frozen after it.
    always_comb begin
        idx_ext = LEN_W'(idx_q);
        clen    = bus.len;
        if (bus.len == '0 || bus.len > N_L) begin
            clen = N_L;
        end else if (bus.len < F_L) begin
            clen = F_L;
        end
        if (idx_ext < F_LAST) begin
            lim = N_L;
        end else if (idx_ext == F_LAST) begin
            lim = clen;
        end else begin
            lim = len_reg_q;
        end
        last = (idx_ext == lim - ONE_L);
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_reg_d = len_reg_q;
        cnt_d     = cnt_q;
        adv       = 1'b0;
        step_rise = bus.step & ~step_q;
        case (state_q)
            RUNNING: begin
                if (bus.hlt) begin
                    state_d = HALTED;
                end else if (bus.en && (!bus.mode_step || step_rise)) begin
                    adv = 1'b1;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
        endcase
        if (adv) begin
            if (idx_ext == F_LAST) begin
                len_reg_d = clen;
            end
            // An out-of-range index restarts at T1 without counting an instruction.
            if (idx_ext >= N_L) begin
                idx_d = '0;
            end else if (last) begin
                idx_d = '0;
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q   <= RUNNING;
            idx_q     <= '0;
            t_q       <= N_STATES'(1);
            len_reg_q <= N_L;
            cnt_q     <= '0;
            step_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            t_q       <= N_STATES'(1) << idx_d;
            len_reg_q <= len_reg_d;
            cnt_q     <= cnt_d;
            step_q    <= bus.step;
        end
    end

    assign bus.t         = t_q;
    assign bus.idx       = idx_q;
    assign bus.fetch     = (idx_ext < F_L);
    assign bus.last      = last;
    assign bus.halted    = (state_q == HALTED);
    assign bus.instr_cnt = cnt_q;
endmodule
